spi_master: RTL and testbench

Command-driven SPI master that sits directly upstream of the SPI slave/RAM wrapper, turning parallel requests (command + byte) into SS_n/MOSI frames and collecting MISO read bytes. Uses the same system clock as the slave (one bit per `clk`), so frames are cycle-exact. Host logic issues requests over a valid/ready handshake and receives read-data bytes on a one-cycle response strobe.

---
 rtl/spi_master_pkg.sv | 37 +++
 rtl/spi_master_if.sv | 23 ++
 rtl/spi_master_shreg.sv | 45 ++++
 rtl/spi_master.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_master.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_pkg.sv
// spi_pkg: shared encodings, FSM states and frame geometry for the SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } spi_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT_TX,
        ST_TURN,
        ST_SHIFT_RX,
        ST_GAP,
        ST_ERR
    } spi_state_e;

    typedef enum logic [1:0] {
        TRK_NONE,
        TRK_WR,
        TRK_RD
    } addr_track_e;

    localparam int FRAME_W   = 10;
    localparam int START_LEN = 2;
    localparam int RX_LEN    = 8;
    localparam int CNT_W     = 4;

    // Reload value for the shared down-counter: a state lasting len cycles counts len-1..0.
    function automatic logic [CNT_W-1:0] cnt_load(input int len);
        return CNT_W'(len - 1);
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: request/response handshake between host logic and the SPI master.
interface spi_master_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_cmd;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;

    // Host side: issues requests, consumes responses.
    modport master (
        output req_valid, req_cmd, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy
    );

    // SPI master side: accepts requests, produces responses.
    modport slave (
        input  req_valid, req_cmd, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/spi_master_shreg.sv
// spi_master_shreg: loadable 10-bit MSB-first TX shifter plus 8-bit MSB-first RX capture.
module spi_master_shreg
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_frame,
    input  logic               tx_shift,
    input  logic               rx_shift,
    input  logic               rx_bit,
    output logic               tx_msb,
    output logic [RX_LEN-1:0]  rx_next
);
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [RX_LEN-1:0]  rx_q, rx_d;

    assign tx_msb  = tx_q[FRAME_W-1];
    assign rx_next = {rx_q[RX_LEN-2:0], rx_bit};

    // Load a new frame on acceptance, otherwise shift left while the master drives bits out.
    always_comb begin
        tx_d = tx_q;
        rx_d = rx_q;
        if (load) begin
            tx_d = load_frame;
        end else if (tx_shift) begin
            tx_d = {tx_q[FRAME_W-2:0], 1'b0};
        end
        if (rx_shift) begin
            rx_d = rx_next;
        end
    end

    // Shift register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            tx_q <= tx_d;
            rx_q <= rx_d;
        end
    end
endmodule

// File: rtl/spi_master.sv
// spi_master: turns command+byte requests into cycle-exact SS_n/MOSI frames, collects MISO reads.
// Optional build macro: SPI_MASTER_SEQ_CHECK_EN rejects data commands lacking a matching address command.
module spi_master
    import spi_pkg::*;
#(
    parameter int TURNAROUND = 2,
    parameter int GAP        = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_master_if.slave bus,
    output logic        SS_n,
    output logic        MOSI,
    input  logic        MISO
);
    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_read_q, is_read_d;
    logic              ss_n_q, ss_n_d;
    logic              mosi_q, mosi_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [RX_LEN-1:0] rsp_data_q, rsp_data_d;
    logic [RX_LEN-1:0] rx_next;
    logic              accept, seq_ok, load, tx_shift, rx_shift, tx_msb;

    assign accept   = bus.req_valid && ready_q;
    assign load     = accept;
    assign tx_shift = (state_d == ST_SHIFT_TX);
    assign rx_shift = (state_q == ST_SHIFT_RX);

`ifdef SPI_MASTER_SEQ_CHECK_EN
    addr_track_e last_q, last_d;
    logic        rsp_err_q, rsp_err_d;

    // Judge data commands against the last address command; rejected commands leave tracking alone.
    always_comb begin
        last_d = last_q;
        seq_ok = 1'b1;
        case (bus.req_cmd)
            CMD_WR_ADDR: last_d = TRK_WR;
            CMD_RD_ADDR: last_d = TRK_RD;
            CMD_WR_DATA: begin
                seq_ok = (last_q == TRK_WR);
                if (seq_ok) last_d = TRK_NONE;
            end
            default: begin
                seq_ok = (last_q == TRK_RD);
                if (seq_ok) last_d = TRK_NONE;
            end
        endcase
        if (!accept) last_d = last_q;
    end

    assign rsp_err_d = (state_d == ST_ERR);

    // Tracking and error strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= TRK_NONE;
            rsp_err_q <= 1'b0;
        end else begin
            last_q    <= last_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign seq_ok      = 1'b1;
    assign bus.rsp_err = 1'b0;
`endif

    spi_master_shreg u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_frame ({bus.req_cmd, bus.req_data}),
        .tx_shift   (tx_shift),
        .rx_shift   (rx_shift),
        .rx_bit     (MISO),
        .tx_msb     (tx_msb),
        .rx_next    (rx_next)
    );

    // State register, shared counter and latched read flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_read_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_read_q <= is_read_d;
        end
    end

    // Next-state logic; the counter is reloaded on every transition and counts down to zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_read_d = is_read_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    is_read_d = (bus.req_cmd == CMD_RD_DATA);
                    if (seq_ok) begin
                        state_d = ST_START;
                        cnt_d   = cnt_load(START_LEN);
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    state_d = ST_SHIFT_TX;
                    cnt_d   = cnt_load(FRAME_W);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SHIFT_TX: begin
                if (cnt_q == '0) begin
                    if (is_read_q) begin
                        state_d = ST_TURN;
                        cnt_d   = cnt_load(TURNAROUND);
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = cnt_load(GAP);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_TURN: begin
                if (cnt_q == '0) begin
                    state_d = ST_SHIFT_RX;
                    cnt_d   = cnt_load(RX_LEN);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SHIFT_RX: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = cnt_load(GAP);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the state being entered, so every output is a flop aligned with its state.
    always_comb begin
        ss_n_d      = 1'b1;
        mosi_d      = 1'b0;
        ready_d     = 1'b0;
        busy_d      = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            ST_START: begin
                ss_n_d = 1'b0;
                mosi_d = (state_q == ST_IDLE) ? bus.req_cmd[1] : tx_msb;
            end
            ST_SHIFT_TX: begin
                ss_n_d = 1'b0;
                mosi_d = tx_msb;
            end
            ST_TURN, ST_SHIFT_RX: begin
                ss_n_d = 1'b0;
            end
            ST_GAP: begin
                if (state_q == ST_SHIFT_RX) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_next;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign SS_n          = ss_n_q;
    assign MOSI          = mosi_q;
    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized scoreboard bench for spi_master with a behavioural SPI RAM slave.
// Honours SPI_MASTER_SEQ_CHECK_EN when the build defines it.
module tb_spi_master;
   localparam int TURNAROUND = 2;
   localparam int GAP        = 1;

   typedef struct {
      int          acc;
      logic [11:0] bits;
      int          len;
   } frame_t;

   typedef struct {
      int         acc;
      logic [7:0] data;
   } rsp_t;

   logic clk;
   logic rst_n;
   logic SS_n;
   logic MOSI;
   logic MISO;

   spi_master_if bus ();

   spi_master #(.TURNAROUND(TURNAROUND), .GAP(GAP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .SS_n  (SS_n),
      .MOSI  (MOSI),
      .MISO  (MISO)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int framesSeen = 0;
   int framesPushed = 0;

   frame_t expFrames[$];
   rsp_t   expRsp[$];
   int     expErr[$];

   logic [7:0] modelRam[256];
   logic [7:0] modelWa;
   logic [7:0] modelRa;
   int         lastAddr;

   logic [7:0] devRam[256];
   logic [7:0] devWa;
   logic [7:0] devRa;
   logic [7:0] devRdByte;

   bit     inFrame = 0;
   bit     haveLastEnd = 0;
   bit     busyOk;
   int     startCyc;
   int     lastEndCyc;
   logic   obs[$];
   frame_t monFrame;
   rsp_t   monRsp;

   // Free-running clock and a cycle counter used as the timing reference.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic failNow(input string name, input string msg);
      total++;
      bad++;
      $display("[TB] FAIL %s: %s", name, msg);
   endtask

   // Frame content as seen on MOSI: two START cycles carrying cmd[1], then cmd and data MSB first.
   function automatic logic [11:0] expBits(input logic [1:0] cmd, input logic [7:0] data);
      return {cmd[1], cmd[1], cmd, data};
   endfunction

   function automatic int lowLen(input logic [1:0] cmd);
      return (cmd == 2'd3) ? 12 + TURNAROUND + 8 : 12;
   endfunction

   // Behavioural slave: decodes the 12 transmitted bits, updates its RAM, and serves read bytes.
   task automatic deviceDecode();
      logic [1:0] c;
      logic [7:0] d;
      c = {obs[2], obs[3]};
      d = 8'h00;
      for (int i = 4; i < 12; i++) d = {d[6:0], obs[i]};
      case (c)
         2'd0: devWa = d;
         2'd1: devRam[devWa] = d;
         2'd2: devRa = d;
         default: devRdByte = devRam[devRa];
      endcase
   endtask

   // Monitor: watches SS_n frames, drives MISO, and checks responses against the scoreboard queues.
   always @(negedge clk) begin
      if (!rst_n) begin
         inFrame = 0;
         haveLastEnd = 0;
         MISO = 1'b0;
      end else begin
         if (!SS_n) begin
            if (!inFrame) begin
               inFrame = 1;
               startCyc = cyc;
               obs.delete();
               busyOk = 1;
               if (haveLastEnd) checkOutput("ss_high_gap_ok", (startCyc - lastEndCyc) >= GAP, 1);
            end
            obs.push_back(MOSI);
            if (!bus.busy || bus.req_ready) busyOk = 0;
            if (obs.size() == 12) deviceDecode();
            MISO = 1'b0;
            if (obs.size() >= 13 + TURNAROUND && obs.size() <= 20 + TURNAROUND)
               MISO = devRdByte[7 - (obs.size() - 13 - TURNAROUND)];
         end else if (inFrame) begin
            logic [11:0] got;
            int          turnVal;
            inFrame = 0;
            haveLastEnd = 1;
            lastEndCyc = cyc;
            MISO = 1'b0;
            framesSeen++;
            if (expFrames.size() == 0) begin
               failNow("frame_unexpected", "SS_n frame with no request outstanding");
            end else begin
               monFrame = expFrames.pop_front();
               checkOutput("ss_start", startCyc, monFrame.acc);
               checkOutput("ss_len", obs.size(), monFrame.len);
               got = 12'h000;
               turnVal = 0;
               if (obs.size() >= 12) for (int i = 0; i < 12; i++) got = {got[10:0], obs[i]};
               checkOutput("mosi_bits", got, monFrame.bits);
               if (monFrame.len > 12 && obs.size() >= 12 + TURNAROUND) begin
                  for (int i = 12; i < 12 + TURNAROUND; i++) turnVal = (turnVal << 1) | int'(obs[i]);
                  checkOutput("mosi_turn", turnVal, 0);
               end
               checkOutput("busy_in_frame", busyOk, 1);
            end
         end
         if (bus.rsp_valid) begin
            if (expRsp.size() == 0) begin
               failNow("rsp_unexpected", "rsp_valid with no read outstanding");
            end else begin
               monRsp = expRsp.pop_front();
               checkOutput("rsp_data", bus.rsp_data, monRsp.data);
               checkOutput("rsp_time", cyc, monRsp.acc + 12 + TURNAROUND + 8);
            end
         end
         if (bus.rsp_err) begin
            if (expErr.size() == 0) begin
               failNow("err_unexpected", "rsp_err with no rejection expected");
            end else begin
               checkOutput("err_time", cyc, expErr.pop_front());
            end
         end
      end
   end

   // Handshake only: call at a negedge; returns just after the accepting edge, acc=-1 on timeout.
   task automatic acceptOne(input logic [1:0] cmd, input logic [7:0] data, output int acc);
      int n;
      bus.req_valid = 1'b1;
      bus.req_cmd = cmd;
      bus.req_data = data;
      n = 0;
      while (!bus.req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         failNow("accept_timeout", "req_ready never rose");
         acc = -1;
         return;
      end
      @(posedge clk);
      #1;
      acc = cyc;
   endtask

   // Issue one request, record the model's expectations, then wait for req_ready to return.
   task automatic applyStimulus(input logic [1:0] cmd, input logic [7:0] data, input bit hold);
      int     acc;
      int     n;
      int     expReady;
      bit     send;
      frame_t f;
      rsp_t   r;
      acceptOne(cmd, data, acc);
      if (acc < 0) return;
      send = 1;
`ifdef SPI_MASTER_SEQ_CHECK_EN
      if (cmd == 2'd1) begin
         send = (lastAddr == 1);
         if (send) lastAddr = 0;
      end else if (cmd == 2'd3) begin
         send = (lastAddr == 2);
         if (send) lastAddr = 0;
      end else begin
         lastAddr = (cmd == 2'd0) ? 1 : 2;
      end
`endif
      if (send) begin
         f.acc = acc;
         f.bits = expBits(cmd, data);
         f.len = lowLen(cmd);
         expFrames.push_back(f);
         framesPushed++;
         case (cmd)
            2'd0: modelWa = data;
            2'd1: modelRam[modelWa] = data;
            2'd2: modelRa = data;
            default: begin
               r.acc = acc;
               r.data = modelRam[modelRa];
               expRsp.push_back(r);
            end
         endcase
         expReady = acc + lowLen(cmd) + GAP;
      end else begin
         expErr.push_back(acc);
         expReady = acc + 1;
      end
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
      n = 0;
      while (!bus.req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) failNow("ready_timeout", "req_ready did not return");
      else checkOutput("ready_return", cyc, expReady);
   endtask

   initial begin
      int acc;
      rst_n = 1'b0;
      MISO = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_cmd = 2'd0;
      bus.req_data = 8'h00;
      lastAddr = 0;
      modelWa = 8'h00;
      modelRa = 8'h00;
      devWa = 8'h00;
      devRa = 8'h00;
      devRdByte = 8'h00;
      for (int i = 0; i < 256; i++) begin
         modelRam[i] = 8'($urandom);
         devRam[i] = modelRam[i];
      end

      repeat (2) @(negedge clk);
      checkOutput("rst_ss_n", SS_n, 1);
      checkOutput("rst_mosi", MOSI, 0);
      checkOutput("rst_req_ready", bus.req_ready, 1);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
      checkOutput("rst_rsp_err", bus.rsp_err, 0);
      checkOutput("rst_rsp_data", bus.rsp_data, 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] directed write/read sequence");
      applyStimulus(2'd0, 8'h3C, 0);
      applyStimulus(2'd0, 8'h10, 0);
      applyStimulus(2'd1, 8'hA5, 0);
      applyStimulus(2'd2, 8'h10, 0);
      applyStimulus(2'd3, 8'h00, 0);
      repeat (2) @(negedge clk);
      checkOutput("rsp_data_held_a5", bus.rsp_data, 8'hA5);

      $display("[TB] req_valid held across frames");
      for (int i = 0; i < 4; i++) applyStimulus(2'd0, 8'($urandom), 1);
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] reset during SHIFT_TX");
      acceptOne(2'd3, 8'h00, acc);
      repeat (4) @(negedge clk);
      checkOutput("ss_low_before_reset", SS_n, 0);
      #2;
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      #1;
      checkOutput("midrst_ss_n", SS_n, 1);
      checkOutput("midrst_mosi", MOSI, 0);
      checkOutput("midrst_busy", bus.busy, 0);
      checkOutput("midrst_req_ready", bus.req_ready, 1);
      lastAddr = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(2'd3, 8'h00, 0);

      $display("[TB] randomized requests");
      for (int i = 0; i < 40; i++) begin
         applyStimulus(2'($urandom_range(0, 3)), 8'($urandom), 0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (40) @(negedge clk);
      checkOutput("frames_pending", expFrames.size(), 0);
      checkOutput("rsp_pending", expRsp.size(), 0);
      checkOutput("err_pending", expErr.size(), 0);
      checkOutput("frame_count", framesSeen, framesPushed);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run always ends even if the DUT stalls.
   initial begin
      #500000;
      bad++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
